// File: rtl/vga_out_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types, TinyVGA bit map and default 640x480 timing for
//                the VGA output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // Per-coordinate attributes carried through the alignment delay line
    typedef struct packed {
        logic    hs;
        logic    vs;
        logic    active;
        logic    pat_en;
        rgb222_t pat;
    } vga_stage_t;

    localparam int c_bit_hs = 7;
    localparam int c_bit_vs = 3;
    localparam int c_bit_r1 = 0;
    localparam int c_bit_g1 = 1;
    localparam int c_bit_b1 = 2;
    localparam int c_bit_r0 = 4;
    localparam int c_bit_g0 = 5;
    localparam int c_bit_b0 = 6;

    localparam int c_def_h_active = 640;
    localparam int c_def_h_fp     = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_bp     = 48;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_fp     = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_bp     = 33;

    function automatic logic [7:0] pack_tinyvga(input logic hs, input logic vs,
                                                input rgb222_t c);
        logic [7:0] v;
        v           = '0;
        v[c_bit_hs] = hs;
        v[c_bit_vs] = vs;
        v[c_bit_r1] = c.r[1];
        v[c_bit_r0] = c.r[0];
        v[c_bit_g1] = c.g[1];
        v[c_bit_g0] = c.g[0];
        v[c_bit_b1] = c.b[1];
        v[c_bit_b0] = c.b[0];
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_out_stage_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Pixel/line counters, sync and active decode, start pulses and
//                frame counter, all advancing on the pixel enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pix_ce,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_cnt,
    output logic       o_hs,
    output logic       o_vs
);

    localparam int   c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   c_hs_start = H_ACTIVE + H_FP;
    localparam int   c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
    localparam int   c_vs_start = V_ACTIVE + V_FP;
    localparam int   c_vs_end   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic c_hs_on    = (HS_POL != 0);
    localparam logic c_vs_on    = (VS_POL != 0);

    generate
        if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_total
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [7:0] r_frame_cnt;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;

    assign w_x_wrap = (r_x == 10'(c_h_total - 1));
    assign w_y_wrap = (r_y == 10'(c_v_total - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (i_pix_ce) begin
            if (w_x_wrap) begin
                r_x <= '0;
                if (w_y_wrap) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_y <= r_y + 10'd1;
                end
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Decode in 11 bits so region bounds equal to 1024 still compare correctly
    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_active      = (w_x_ext < 11'(H_ACTIVE)) && (w_y_ext < 11'(V_ACTIVE));
    assign o_line_start  = (r_x == 10'd0);
    assign o_frame_start = (r_x == 10'd0) && (r_y == 10'd0);
    assign o_hs = ((w_x_ext >= 11'(c_hs_start)) && (w_x_ext < 11'(c_hs_end)))
                  ? c_hs_on : ~c_hs_on;
    assign o_vs = ((w_y_ext >= 11'(c_vs_start)) && (w_y_ext < 11'(c_vs_end)))
                  ? c_vs_on : ~c_vs_on;

endmodule
`default_nettype wire

// File: rtl/vga_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vga_out_stage
//  Description : VGA back end: timing, latency-matched sync delay line, colour
//                select (inputs or colour bars) and registered TinyVGA bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = c_def_h_active,
    parameter int H_FP       = c_def_h_fp,
    parameter int H_SYNC     = c_def_h_sync,
    parameter int H_BP       = c_def_h_bp,
    parameter int V_ACTIVE   = c_def_v_active,
    parameter int V_FP       = c_def_v_fp,
    parameter int V_SYNC     = c_def_v_sync,
    parameter int V_BP       = c_def_v_bp,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int PIX_LAT    = 1,
    parameter int COLOR_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       pattern_en,
    input  logic       mono_i,
    input  logic [5:0] rgb_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       active_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_cnt_o,
    output logic [7:0] uo_out
);

    localparam logic c_hs_on = (HS_POL != 0);
    localparam logic c_vs_on = (VS_POL != 0);

    generate
        if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
            $error("vga_out_stage: PIX_LAT must be within 0..4");
        end
    endgenerate

    logic       w_hs;
    logic       w_vs;
    logic [2:0] w_bar_idx;
    vga_stage_t w_stage;
    vga_stage_t w_blank;
    vga_stage_t w_delayed;
    rgb222_t    w_color;
    logic [7:0] r_uo;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pix_ce      (pix_ce),
        .o_x           (x_o),
        .o_y           (y_o),
        .o_active      (active_o),
        .o_line_start  (line_start_o),
        .o_frame_start (frame_start_o),
        .o_frame_cnt   (frame_cnt_o),
        .o_hs          (w_hs),
        .o_vs          (w_vs)
    );

    // Bar index = floor(x*8/H_ACTIVE): x reaches bar i at ceil(i*H_ACTIVE/8)
    always_comb begin
        w_bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if ({1'b0, x_o} >= 11'((i * H_ACTIVE + 7) / 8)) begin
                w_bar_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_stage.hs     = w_hs;
        w_stage.vs     = w_vs;
        w_stage.active = active_o;
        w_stage.pat_en = pattern_en;
        w_stage.pat.r  = {2{w_bar_idx[2]}};
        w_stage.pat.g  = {2{w_bar_idx[1]}};
        w_stage.pat.b  = {2{w_bar_idx[0]}};
    end

    always_comb begin
        w_blank    = '0;
        w_blank.hs = ~c_hs_on;
        w_blank.vs = ~c_vs_on;
    end

    generate
        if (PIX_LAT == 0) begin : g_no_delay
            assign w_delayed = w_stage;
        end else begin : g_delay
            vga_stage_t r_pipe [PIX_LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        r_pipe[i] <= w_blank;
                    end
                end else if (pix_ce) begin
                    r_pipe[0] <= w_stage;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_delayed = r_pipe[PIX_LAT-1];
        end
    endgenerate

    always_comb begin
        if (!w_delayed.active) begin
            w_color = '0;
        end else if (w_delayed.pat_en) begin
            w_color = w_delayed.pat;
        end else if (COLOR_MODE == 0) begin
            w_color = rgb222_t'({6{mono_i}});
        end else begin
            w_color = rgb222_t'(rgb_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_uo <= pack_tinyvga(~c_hs_on, ~c_vs_on, '0);
        end else if (pix_ce) begin
            r_uo <= pack_tinyvga(w_delayed.hs, w_delayed.vs, w_color);
        end
    end

    assign uo_out = r_uo;

endmodule
`default_nettype wire

// File: tb/tb_vga_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_out_stage
//  Description : Randomised self-checking bench for vga_out_stage on a small
//                16x8 raster, one RGB222 (latency 2) and one mono (latency 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_out_stage;

    localparam int c_ht = 16;
    localparam int c_vt = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic       pattern_en = 1'b0;
    logic       mono_i = 1'b0;
    logic [5:0] rgb_i = '0;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_act, a_ls, a_fs, b_act, b_ls, b_fs;
    logic [7:0] a_fc, b_fc, a_uo, b_uo;

    int vectors = 0;
    int miscompares = 0;
    int e = 0;
    int pat_mode = 0;
    bit         pat_h  [8];
    bit         mono_h [8];
    logic [5:0] rgb_h  [8];

    always #5 clk = ~clk;

    vga_out_stage #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(2), .COLOR_MODE(1)
    ) u_dut_rgb (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pattern_en(pattern_en),
        .mono_i(mono_i), .rgb_i(rgb_i), .x_o(a_x), .y_o(a_y),
        .active_o(a_act), .line_start_o(a_ls), .frame_start_o(a_fs),
        .frame_cnt_o(a_fc), .uo_out(a_uo)
    );

    vga_out_stage #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(1), .COLOR_MODE(0)
    ) u_dut_mono (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pattern_en(pattern_en),
        .mono_i(mono_i), .rgb_i(rgb_i), .x_o(b_x), .y_o(b_y),
        .active_o(b_act), .line_start_o(b_ls), .frame_start_o(b_fs),
        .frame_cnt_o(b_fc), .uo_out(b_uo)
    );

    // Reference: after e enables the raster position is simply e mod 128;
    // the bus shows coordinate e-1-lat, its colour sampled at enable e.
    function automatic logic [7:0] exp_uo(input int en, input int lat, input bit mono);
        int t, x, y, idx;
        bit hs, vs, act;
        logic [5:0] col;
        t = en - 1 - lat;
        if (t < 0) return 8'b1000_1000;
        x   = t % c_ht;
        y   = (t / c_ht) % c_vt;
        hs  = !(x >= 10 && x < 13);
        vs  = !(y >= 5 && y < 7);
        act = (x < 8) && (y < 4);
        idx = (x * 8) / 8;
        if (!act)                    col = 6'b0;
        else if (pat_h[(t + 1) % 8]) col = {idx[2], idx[2], idx[1], idx[1], idx[0], idx[0]};
        else if (mono)               col = {6{mono_h[en % 8]}};
        else                         col = rgb_h[en % 8];
        return {hs, col[0], col[2], col[4], vs, col[1], col[3], col[5]};
    endfunction

    task automatic step(input bit ce, input bit rst);
        rst_n  = !rst;
        pix_ce = ce;
        pattern_en = (pat_mode == 2) ? 1'($urandom % 2) : 1'(pat_mode);
        rgb_i  = 6'($urandom);
        mono_i = 1'($urandom);
        @(posedge clk);
        if (rst) begin
            e = 0;
        end else if (ce) begin
            e++;
            pat_h[e % 8]  = pattern_en;
            rgb_h[e % 8]  = rgb_i;
            mono_h[e % 8] = mono_i;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        step(0, 1);
        step(1, 1);
        vectors += 8;
        if (a_x !== 10'd0)     begin miscompares++; $display("FAIL reset_x got %0d want 0", a_x); end
        if (a_y !== 10'd0)     begin miscompares++; $display("FAIL reset_y got %0d want 0", a_y); end
        if (a_fc !== 8'd0)     begin miscompares++; $display("FAIL reset_fcnt got %0d want 0", a_fc); end
        if (a_act !== 1'b1)    begin miscompares++; $display("FAIL reset_active got %b want 1", a_act); end
        if (a_ls !== 1'b1)     begin miscompares++; $display("FAIL reset_line_start got %b want 1", a_ls); end
        if (a_fs !== 1'b1)     begin miscompares++; $display("FAIL reset_frame_start got %b want 1", a_fs); end
        if (a_uo !== 8'h88)    begin miscompares++; $display("FAIL reset_uo_rgb got %h want 88", a_uo); end
        if (b_uo !== 8'h88)    begin miscompares++; $display("FAIL reset_uo_mono got %h want 88", b_uo); end
    endtask

    task automatic test_timing;
        int x, y;
        pat_mode = 0;
        for (int n = 0; n < 3 * c_ht * c_vt; n++) begin
            step(1, 0);
            x = e % c_ht;
            y = (e / c_ht) % c_vt;
            vectors += 8;
            if (a_x !== 10'(x)) begin miscompares++; $display("FAIL timing_x e=%0d got %0d want %0d", e, a_x, x); end
            if (a_y !== 10'(y)) begin miscompares++; $display("FAIL timing_y e=%0d got %0d want %0d", e, a_y, y); end
            if (a_act !== 1'(x < 8 && y < 4)) begin miscompares++; $display("FAIL timing_active e=%0d got %b want %b", e, a_act, (x < 8 && y < 4)); end
            if (a_ls !== 1'(x == 0)) begin miscompares++; $display("FAIL timing_line_start e=%0d got %b", e, a_ls); end
            if (a_fs !== 1'(x == 0 && y == 0)) begin miscompares++; $display("FAIL timing_frame_start e=%0d got %b", e, a_fs); end
            if (a_fc !== 8'((e / 128) % 256)) begin miscompares++; $display("FAIL timing_fcnt e=%0d got %0d want %0d", e, a_fc, (e / 128) % 256); end
            if (a_uo !== exp_uo(e, 2, 0)) begin miscompares++; $display("FAIL timing_uo_rgb e=%0d got %h want %h", e, a_uo, exp_uo(e, 2, 0)); end
            if (b_uo !== exp_uo(e, 1, 1)) begin miscompares++; $display("FAIL timing_uo_mono e=%0d got %h want %h", e, b_uo, exp_uo(e, 1, 1)); end
        end
    endtask

    task automatic test_pattern;
        pat_mode = 2;
        for (int n = 0; n < 2 * c_ht * c_vt; n++) begin
            step(1, 0);
            vectors += 2;
            if (a_uo !== exp_uo(e, 2, 0)) begin miscompares++; $display("FAIL pattern_uo_rgb e=%0d got %h want %h", e, a_uo, exp_uo(e, 2, 0)); end
            if (b_uo !== exp_uo(e, 1, 1)) begin miscompares++; $display("FAIL pattern_uo_mono e=%0d got %h want %h", e, b_uo, exp_uo(e, 1, 1)); end
        end
    endtask

    task automatic test_pix_ce;
        pat_mode = 2;
        for (int n = 0; n < 600; n++) begin
            step(((n % 2) == 0) ? 1'b1 : 1'($urandom % 2), 0);
            vectors += 4;
            if (a_x !== 10'(e % c_ht)) begin miscompares++; $display("FAIL ce_x e=%0d got %0d want %0d", e, a_x, e % c_ht); end
            if (a_y !== 10'((e / c_ht) % c_vt)) begin miscompares++; $display("FAIL ce_y e=%0d got %0d want %0d", e, a_y, (e / c_ht) % c_vt); end
            if (a_uo !== exp_uo(e, 2, 0)) begin miscompares++; $display("FAIL ce_uo_rgb e=%0d got %h want %h", e, a_uo, exp_uo(e, 2, 0)); end
            if (b_uo !== exp_uo(e, 1, 1)) begin miscompares++; $display("FAIL ce_uo_mono e=%0d got %h want %h", e, b_uo, exp_uo(e, 1, 1)); end
        end
    endtask

    task automatic test_reset_mid;
        pat_mode = 0;
        step(1, 1);
        while (e != 2 * c_ht + 9) step(1, 0);
        step(1, 1);
        for (int n = 0; n < 6; n++) begin
            vectors += 4;
            if (a_x !== 10'(e)) begin miscompares++; $display("FAIL rstmid_x e=%0d got %0d want %0d", e, a_x, e); end
            if (a_y !== 10'd0) begin miscompares++; $display("FAIL rstmid_y e=%0d got %0d want 0", e, a_y); end
            if (a_uo !== exp_uo(e, 2, 0)) begin miscompares++; $display("FAIL rstmid_uo_rgb e=%0d got %h want %h", e, a_uo, exp_uo(e, 2, 0)); end
            if (b_uo !== exp_uo(e, 1, 1)) begin miscompares++; $display("FAIL rstmid_uo_mono e=%0d got %h want %h", e, b_uo, exp_uo(e, 1, 1)); end
            step(1, 0);
        end
    endtask

    task automatic test_frame_wrap;
        pat_mode = 0;
        step(1, 1);
        for (int n = 0; n < 256 * c_ht * c_vt; n++) begin
            step(1, 0);
            if ((e % 128) == 0 || (e % 128) == 127) begin
                vectors += 2;
                if (a_fc !== 8'((e / 128) % 256)) begin miscompares++; $display("FAIL wrap_fcnt e=%0d got %0d want %0d", e, a_fc, (e / 128) % 256); end
                if (a_fs !== 1'((e % 128) == 0)) begin miscompares++; $display("FAIL wrap_frame_start e=%0d got %b", e, a_fs); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_timing;
        test_pattern;
        test_pix_ce;
        test_reset_mid;
        test_frame_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
